// File: rtl/scandoubler_rotate_port.sv
// Memory-side responder for the rotating scandoubler: serves client write bursts and
// row-fetch reads, transposing addresses so each rotated output row is contiguous.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | arbitrate between write burst and read row segment
// WR_ISSUE    | single-word write held on the memory port until mem_ack
// WR_SETTLE   | two cycles for the client to register its next word/column
// RD_ISSUE    | 8-word burst read held on the memory port until mem_ack
// RD_DATA     | forward (or discard) the 8 returned words
// RD_SETTLE   | two cycles for the client X counter to settle
module scandoubler_rotate_port #(
    parameter int                HCNT_WIDTH = 10,
    parameter int                MEM_AW     = 24,
    parameter logic [MEM_AW-1:0] BASE_ADDR  = 24'h000000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  vidin_req,
    input  logic                  vidin_frame,
    input  logic [HCNT_WIDTH-1:0] vidin_row,
    input  logic [HCNT_WIDTH-1:0] vidin_col,
    input  logic [15:0]           vidin_d,
    output logic                  vidin_ack,
    input  logic                  vidout_req,
    input  logic                  vidout_frame,
    input  logic [HCNT_WIDTH-1:0] vidout_row,
    input  logic [HCNT_WIDTH-1:0] vidout_col,
    output logic [15:0]           vidout_d,
    output logic                  vidout_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [15:0]           mem_d,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_q,
    input  logic                  mem_valid
);

    localparam int FW = 2 * HCNT_WIDTH + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_ISSUE  = 3'd1;
    localparam logic [2:0] S_WR_SETTLE = 3'd2;
    localparam logic [2:0] S_RD_ISSUE  = 3'd3;
    localparam logic [2:0] S_RD_DATA   = 3'd4;
    localparam logic [2:0] S_RD_SETTLE = 3'd5;

    // Reads always start on an 8-word boundary of the output row.
    localparam logic [FW-1:0] RD_MASK = ~(FW'(7));

    logic [2:0]        state;
    logic              last_wr;
    logic [4:0]        word_cnt;
    logic [2:0]        beat_cnt;
    logic              settle_tmr;

    logic [FW-1:0]     wr_field;
    logic [FW-1:0]     rd_field;
    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_addr;

    // Cornerturn: writes put the column in the high half, reads put the row there.
    assign wr_field = {vidin_frame, vidin_col, vidin_row};
    assign rd_field = {vidout_frame, vidout_row, vidout_col} & RD_MASK;
    assign wr_addr  = BASE_ADDR + MEM_AW'(wr_field);
    assign rd_addr  = BASE_ADDR + MEM_AW'(rd_field);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_wr    <= 1'b0;
            word_cnt   <= 5'd0;
            beat_cnt   <= 3'd0;
            settle_tmr <= 1'b0;
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;
            vidout_d   <= 16'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_d      <= 16'd0;
        end else begin
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vidin_req && (!vidout_req || !last_wr)) begin
                        state    <= S_WR_ISSUE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= wr_addr;
                        mem_d    <= vidin_d;
                    end else if (vidout_req) begin
                        state    <= S_RD_ISSUE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_addr;
                    end
                end
                S_WR_ISSUE: begin
                    if (mem_req && mem_ack) begin
                        mem_req    <= 1'b0;
                        vidin_ack  <= 1'b1;
                        word_cnt   <= word_cnt + 5'd1;
                        settle_tmr <= 1'b1;
                        state      <= S_WR_SETTLE;
                    end
                end
                S_WR_SETTLE: begin
                    if (settle_tmr != 1'b0) begin
                        settle_tmr <= settle_tmr - 1'b1;
                    end else if (word_cnt == 5'd16 || !vidin_req) begin
                        state    <= S_IDLE;
                        word_cnt <= 5'd0;
                        last_wr  <= 1'b1;
                    end else begin
                        state    <= S_WR_ISSUE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= wr_addr;
                        mem_d    <= vidin_d;
                    end
                end
                S_RD_ISSUE: begin
                    if (mem_req && mem_ack) begin
                        mem_req  <= 1'b0;
                        beat_cnt <= 3'd0;
                        state    <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (mem_valid) begin
                        // Words arriving after the client dropped its request are discarded.
                        if (vidout_req) begin
                            vidout_d   <= mem_q;
                            vidout_ack <= 1'b1;
                        end
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == 3'd7) begin
                            settle_tmr <= 1'b1;
                            state      <= S_RD_SETTLE;
                        end
                    end
                end
                S_RD_SETTLE: begin
                    if (settle_tmr != 1'b0) begin
                        settle_tmr <= settle_tmr - 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        last_wr <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scandoubler_rotate_port.sv
// Bench for scandoubler_rotate_port: random client traffic against a memory model and
// a scoreboard of expected transposed addresses, data and ack timing.
module tb_scandoubler_rotate_port;

    localparam int BASE = 32'hF00000;

    logic        clk_sys;
    logic        reset_n;
    logic        vidin_req, vidin_frame;
    logic [9:0]  vidin_row, vidin_col;
    logic [15:0] vidin_d;
    logic        vidin_ack;
    logic        vidout_req, vidout_frame;
    logic [9:0]  vidout_row, vidout_col;
    logic [15:0] vidout_d;
    logic        vidout_ack;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_d;
    logic        mem_ack;
    logic [15:0] mem_q;
    logic        mem_valid;

    int n_checks = 0;
    int n_errors = 0;

    int   exp_wr_addr[$];
    int   exp_wr_data[$];
    int   exp_rd_addr[$];
    logic req_log[$];

    // memory model controls / status
    int   ack_fix  = 1;
    logic ack_rand = 1'b0;
    logic spur_en  = 1'b0;
    logic real_wack = 1'b0;
    logic genuine   = 1'b0;
    int   rd_cnt    = 0;

    scandoubler_rotate_port #(
        .HCNT_WIDTH(10),
        .MEM_AW    (24),
        .BASE_ADDR (24'hF00000)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .vidin_req   (vidin_req),
        .vidin_frame (vidin_frame),
        .vidin_row   (vidin_row),
        .vidin_col   (vidin_col),
        .vidin_d     (vidin_d),
        .vidin_ack   (vidin_ack),
        .vidout_req  (vidout_req),
        .vidout_frame(vidout_frame),
        .vidout_row  (vidout_row),
        .vidout_col  (vidout_col),
        .vidout_d    (vidout_d),
        .vidout_ack  (vidout_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_d       (mem_d),
        .mem_ack     (mem_ack),
        .mem_q       (mem_q),
        .mem_valid   (mem_valid)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference addressing: memory word index from frame/row/column arithmetic.
    function automatic int wr_ref(input logic fr, input logic [9:0] col, input logic [9:0] row);
        return (BASE + int'(fr) * 32'h100000 + int'(col) * 1024 + int'(row)) % 32'h1000000;
    endfunction

    function automatic int rd_ref(input logic fr, input logic [9:0] row, input logic [9:0] col);
        return (BASE + int'(fr) * 32'h100000 + int'(row) * 1024 + (int'(col) / 8) * 8) % 32'h1000000;
    endfunction

    // Memory controller model: checks each request, holds it for a delay, returns burst data.
    logic [23:0] m_a;
    logic [15:0] m_d;
    logic        m_we;
    int          m_dly;
    initial begin
        mem_ack = 1'b0; mem_valid = 1'b0; mem_q = 16'd0;
        forever begin
            @(negedge clk_sys);
            mem_ack = 1'b0; mem_valid = 1'b0; genuine = 1'b0; real_wack = 1'b0;
            if (spur_en) begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_valid = 1'($urandom_range(0, 1));
                mem_q     = 16'($urandom);
            end else if (reset_n && mem_req) begin
                m_a = mem_addr; m_d = mem_d; m_we = mem_we;
                req_log.push_back(m_we);
                if (m_we) begin
                    chk("wr_pending", 32'(exp_wr_addr.size() > 0), 1);
                    if (exp_wr_addr.size() > 0) begin
                        chk("wr_addr", 32'(m_a), exp_wr_addr.pop_front());
                        chk("wr_data", 32'(m_d), exp_wr_data.pop_front());
                    end
                end else begin
                    chk("rd_pending", 32'(exp_rd_addr.size() > 0), 1);
                    if (exp_rd_addr.size() > 0)
                        chk("rd_addr", 32'(m_a), exp_rd_addr.pop_front());
                end
                m_dly = ack_rand ? int'($urandom_range(0, 4)) : ack_fix;
                for (int i = 0; i < m_dly; i++) begin
                    @(negedge clk_sys);
                    chk("hold_req", 32'(mem_req), 1);
                    chk("hold_we", 32'(mem_we), 32'(m_we));
                    chk("hold_addr", 32'(mem_addr), 32'(m_a));
                    if (m_we) chk("hold_d", 32'(mem_d), 32'(m_d));
                end
                mem_ack = 1'b1;
                real_wack = m_we;
                @(negedge clk_sys);
                mem_ack = 1'b0;
                real_wack = 1'b0;
                if (!m_we) begin
                    for (int b = 0; b < 8 && reset_n; ) begin
                        if ($urandom_range(0, 3) == 0) begin
                            mem_valid = 1'b0; genuine = 1'b0;
                        end else begin
                            mem_valid = 1'b1; genuine = 1'b1;
                            mem_q = 16'(32'hA000 + rd_cnt);
                            rd_cnt++;
                            b++;
                        end
                        @(negedge clk_sys);
                    end
                    mem_valid = 1'b0; genuine = 1'b0;
                end
            end
        end
    end

    // Ack monitor: each genuine event at an edge must produce exactly one ack right after it.
    initial begin
        forever begin
            @(posedge clk_sys); #1;
            if (reset_n) begin
                chk("vidin_ack", 32'(vidin_ack), 32'(real_wack));
                chk("vidout_ack", 32'(vidout_ack), 32'(genuine && mem_valid && vidout_req));
                if (genuine && mem_valid && vidout_req)
                    chk("vidout_d", 32'(vidout_d), 32'(mem_q));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ack(input logic is_wr, output logic got);
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_sys); #1;
            if (is_wr ? vidin_ack : vidout_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wr_burst(input logic fr, input logic [9:0] row, input logic [9:0] col0,
                            input int nwords, input logic [15:0] d0);
        logic got;
        vidin_frame = fr;
        vidin_row   = row;
        for (int i = 0; i < nwords; i++) begin
            vidin_col = col0 + 10'(i);
            vidin_d   = d0 + 16'(i);
            exp_wr_addr.push_back(wr_ref(fr, vidin_col, row));
            exp_wr_data.push_back(int'(vidin_d));
            vidin_req = 1'b1;
            wait_ack(1'b1, got);
            chk("wr_ack_seen", 32'(got), 1);
            if (!got) break;
            @(negedge clk_sys);
        end
        vidin_req = 1'b0;
    endtask

    task automatic rd_row(input logic fr, input logic [9:0] row, input int nwords, input int abort_after);
        int   limit;
        int   acks;
        logic got;
        limit = (abort_after > 0) ? abort_after : nwords;
        for (int k = 0; k < ((abort_after > 0) ? 1 : nwords / 8); k++)
            exp_rd_addr.push_back(rd_ref(fr, row, 10'(8 * k)));
        vidout_frame = fr;
        vidout_row   = row;
        vidout_col   = 10'd0;
        vidout_req   = 1'b1;
        acks = 0;
        while (acks < limit) begin
            wait_ack(1'b0, got);
            chk("rd_ack_seen", 32'(got), 1);
            if (!got) break;
            acks++;
            @(negedge clk_sys);
            vidout_col = vidout_col + 10'd1;
            if (acks == abort_after) vidout_req = 1'b0;
        end
        vidout_req = 1'b0;
    endtask

    logic exp_log[$];
    int   mism;
    int   cnt;
    logic got_rst;

    initial begin
        reset_n = 1'b0;
        vidin_req = 1'b0; vidin_frame = 1'b0; vidin_row = 10'd0; vidin_col = 10'd0; vidin_d = 16'd0;
        vidout_req = 1'b0; vidout_frame = 1'b0; vidout_row = 10'd0; vidout_col = 10'd0;
        #3;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_vidin_ack", 32'(vidin_ack), 0);
        chk("rst_vidout_ack", 32'(vidout_ack), 0);
        chk("rst_vidout_d", 32'(vidout_d), 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // full 16-word write burst
        wr_burst(1'b1, 10'd5, 10'd32, 16, 16'h1000);
        repeat (4) @(negedge clk_sys);

        // read row of three 8-word segments
        rd_row(1'b0, 10'd7, 24, 0);
        repeat (4) @(negedge clk_sys);

        // contention: last grant was a read, so writes go first and bursts alternate
        req_log.delete();
        fork
            begin
                wr_burst(1'b0, 10'd20, 10'd64, 16, 16'h2000);
                wr_burst(1'b1, 10'd21, 10'd80, 16, 16'h3000);
            end
            rd_row(1'b1, 10'd300, 16, 0);
        join
        exp_log.delete();
        for (int i = 0; i < 16; i++) exp_log.push_back(1'b1);
        exp_log.push_back(1'b0);
        for (int i = 0; i < 16; i++) exp_log.push_back(1'b1);
        exp_log.push_back(1'b0);
        chk("grant_len", 32'(req_log.size()), 34);
        mism = 0;
        for (int i = 0; i < req_log.size() && i < exp_log.size(); i++)
            if (req_log[i] !== exp_log[i]) mism++;
        chk("grant_order", 32'(mism), 0);
        repeat (4) @(negedge clk_sys);

        // abort after the 3rd word of a burst
        rd_row(1'b1, 10'd44, 8, 3);
        cnt = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (mem_req) cnt++;
        end
        chk("abort_idle", 32'(cnt), 0);

        // back-pressure: 20-cycle ack delay
        ack_fix = 20;
        wr_burst(1'b0, 10'd12, 10'd200, 2, 16'h5A00);
        ack_fix = 1;
        repeat (4) @(negedge clk_sys);

        // stray memory handshakes while idle must be ignored
        spur_en = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (mem_req) cnt++;
        end
        spur_en = 1'b0;
        chk("spur_no_req", 32'(cnt), 0);
        repeat (2) @(negedge clk_sys);

        // random traffic
        ack_rand = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                wr_burst(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                         10'($urandom_range(0, 1000)), int'($urandom_range(1, 16)), 16'($urandom));
            else
                rd_row(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                       8 * int'($urandom_range(1, 3)), 0);
            repeat (3) @(negedge clk_sys);
        end
        ack_rand = 1'b0;

        // async reset during RD_DATA
        exp_rd_addr.push_back(rd_ref(1'b0, 10'd9, 10'd0));
        vidout_frame = 1'b0; vidout_row = 10'd9; vidout_col = 10'd0; vidout_req = 1'b1;
        wait_ack(1'b0, got_rst);
        chk("rst_pre_ack", 32'(got_rst), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_vidout_ack", 32'(vidout_ack), 0);
        chk("arst_vidout_d", 32'(vidout_d), 0);
        @(negedge clk_sys);
        vidout_req = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        wr_burst(1'b0, 10'd3, 10'd100, 4, 16'h7700);
        repeat (6) @(negedge clk_sys);

        chk("wr_queue_empty", 32'(exp_wr_addr.size()), 0);
        chk("rd_queue_empty", 32'(exp_rd_addr.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
